conv_pixel_packer: RTL and testbench

Downstream of the convolution ALU in the image-filter coprocessor.
- Accepts one signed 16-bit filtered result per handshake and clamps it to an 8-bit pixel.
- Packs four consecutive pixels into one 32-bit word and writes it into the frame memory at the raster address {v, h[8:2]}.
- Tracks raster position over a 512x480 frame and pulses frame_done after the last word is committed.

---
 rtl/conv_pixel_packer.sv | 154 +++++++++++++++
 tb/tb_conv_pixel_packer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pixel_packer.sv
// conv_pixel_packer: clamps convolution results to bytes, packs four per word.
// Optional macro PACKER_ABS_EN: use |pix_data| before clamping.
module conv_pixel_packer #(
  parameter int H_LAST = 511,
  parameter int V_LAST = 479,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pix_valid,
  input  logic [15:0]       pix_data,
  output logic              pix_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic              mem_done,
  output logic              busy,
  output logic              frame_done,
  output logic [8:0]        h_pos,
  output logic [8:0]        v_pos
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [8:0]      h_d;
  logic [8:0]      v_d;
  logic [2:0][7:0] lane_q;
  logic [2:0][7:0] lane_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]     wdata_d;
  logic [7:0]      pix_byte;
  logic            h_end;
  logic            v_end;

  assign h_end = (h_pos == 9'(H_LAST));
  assign v_end = (v_pos == 9'(V_LAST));

`ifdef PACKER_ABS_EN
  logic [16:0] mag;

  // 17 bits so that -32768 yields +32768 and saturates
  always_comb begin
    mag = pix_data[15] ? (17'd0 - {1'b1, pix_data})
                       : {1'b0, pix_data};
    pix_byte = (|mag[16:8]) ? 8'hFF : mag[7:0];
  end
`else
  always_comb begin
    if (pix_data[15]) begin
      pix_byte = 8'h00;
    end else if (|pix_data[14:8]) begin
      pix_byte = 8'hFF;
    end else begin
      pix_byte = pix_data[7:0];
    end
  end
`endif

  assign pix_ready  = (state_q == COLLECT);
  assign mem_we     = (state_q == WRITE);
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    h_d     = h_pos;
    v_d     = v_pos;
    lane_d  = lane_q;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          h_d     = '0;
          v_d     = '0;
          lane_d  = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (pix_valid) begin
          unique case (h_pos[1:0])
            2'd0: begin
              lane_d[0] = pix_byte;
              h_d       = h_pos + 9'd1;
            end
            2'd1: begin
              lane_d[1] = pix_byte;
              h_d       = h_pos + 9'd1;
            end
            2'd2: begin
              lane_d[2] = pix_byte;
              h_d       = h_pos + 9'd1;
            end
            default: begin
              // lane 3 goes straight into the word
              addr_d  = ADDR_W'({v_pos, h_pos[8:2]});
              wdata_d = {pix_byte, lane_q[2],
                         lane_q[1], lane_q[0]};
              state_d = WRITE;
            end
          endcase
        end
      end
      WRITE: begin
        if (mem_done) begin
          if (h_end && v_end) begin
            state_d = DONE;
          end else if (h_end) begin
            h_d     = '0;
            v_d     = v_pos + 9'd1;
            state_d = COLLECT;
          end else begin
            h_d     = h_pos + 9'd1;
            state_d = COLLECT;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      h_pos     <= '0;
      v_pos     <= '0;
      lane_q    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      h_pos     <= h_d;
      v_pos     <= v_d;
      lane_q    <= lane_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
    end
  end

endmodule

// File: tb/tb_conv_pixel_packer.sv
// tb_conv_pixel_packer: vector table, directed corners and a randomized
// frame checked against a raster/clamp reference model.
module tb_conv_pixel_packer;

  localparam int TB_H_LAST = 31;
  localparam int TB_V_LAST = 5;
  localparam int W = TB_H_LAST + 1;
  localparam int NWORDS = W * (TB_V_LAST + 1) / 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_ready;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_done;
  logic        busy;
  logic        frame_done;
  logic [8:0]  h_pos;
  logic [8:0]  v_pos;

  conv_pixel_packer #(
    .H_LAST(TB_H_LAST),
    .V_LAST(TB_V_LAST),
    .ADDR_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .pix_valid(pix_valid),
    .pix_data(pix_data),
    .pix_ready(pix_ready),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .mem_done(mem_done),
    .busy(busy),
    .frame_done(frame_done),
    .h_pos(h_pos),
    .v_pos(v_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] p0;
    logic [15:0] p1;
    logic [15:0] p2;
    logic [15:0] p3;
    logic [31:0] exp;
    logic [31:0] exp_abs;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    int          cnt;
    int          dly;
  } wr_t;

  int checks = 0;
  int failures = 0;
  int fd_cnt = 0;
  int fix_dly = 0;
  bit rand_dly = 0;
  bit stray_en = 0;
  bit gap_en = 0;

  logic [15:0] q[$];
  logic [15:0] sent[$];
  wr_t         obs[$];
  vec_t        tbl[4];

  task automatic chk(input string name, input logic [79:0] act,
                     input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_clamp(input logic [15:0] x);
    int v;
    v = int'($signed(x));
`ifdef PACKER_ABS_EN
    if (v < 0) v = -v;
`endif
    if (v < 0) return 8'h00;
    if (v > 255) return 8'hFF;
    return v[7:0];
  endfunction

  function automatic logic [15:0] ref_addr(input int w);
    int idx;
    idx = 4 * w;
    return 16'((idx / W) * 128 + (idx % W) / 4);
  endfunction

  function automatic logic [31:0] ref_data(input int w);
    logic [31:0] d;
    d = '0;
    for (int k = 0; k < 4; k++) d[8*k +: 8] = ref_clamp(sent[4*w+k]);
    return d;
  endfunction

  function automatic logic [15:0] rnd_pix();
    case ($urandom_range(0, 2))
      0: return 16'($urandom);
      1: return 16'($urandom_range(0, 300));
      default: return 16'($urandom_range(0, 20)) - 16'd10;
    endcase
  endfunction

  task automatic push(input logic [15:0] d);
    q.push_back(d);
    sent.push_back(d);
  endtask

  task automatic wait_writes(input int n);
    int t = 0;
    while (obs.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("write_timeout", 80'(obs.size() >= n), 80'(1));
  endtask

  task automatic compare_words(input int a, input int b);
    for (int i = a; i < b; i++) begin
      if (i < obs.size()) begin
        chk($sformatf("addr_w%0d", i), 80'(obs[i].addr), 80'(ref_addr(i)));
        chk($sformatf("data_w%0d", i), 80'(obs[i].data), 80'(ref_data(i)));
        chk($sformatf("we_len_w%0d", i), 80'(obs[i].cnt),
            80'(obs[i].dly + 1));
      end
    end
  endtask

  task automatic do_start();
    sent.delete();
    obs.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 80'({busy, pix_ready, h_pos, v_pos}),
        80'({1'b1, 1'b1, 9'd0, 9'd0}));
  endtask

  // pixel source: holds pix_valid until the pixel is consumed
  initial begin
    bit pend;
    pend = 1'b0;
    pix_valid = 1'b0;
    pix_data = '0;
    forever begin
      @(negedge clk);
      if (pend && q.size() > 0) void'(q.pop_front());
      pix_valid = (q.size() > 0) && (!gap_en || $urandom_range(0, 3) != 0);
      pix_data = (q.size() > 0) ? q[0] : 16'h0;
      pend = pix_valid && pix_ready;
    end
  end

  // memory responder and write monitor
  initial begin
    int cnt;
    int dly;
    wr_t cur;
    cnt = 0;
    dly = 0;
    cur = '{default: '0};
    mem_done = 1'b0;
    forever begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
      if (mem_we) begin
        if (cnt == 0) begin
          cur.addr = mem_addr;
          cur.data = mem_wdata;
          dly = rand_dly ? int'($urandom_range(0, 3)) : fix_dly;
          cur.dly = dly;
          chk("ready_in_write", 80'(pix_ready), 80'(0));
        end else begin
          chk("write_hold", 80'({mem_addr, mem_wdata, pix_ready}),
              80'({cur.addr, cur.data, 1'b0}));
        end
        cnt++;
        mem_done = (cnt > dly);
      end else begin
        if (cnt > 0) begin
          cur.cnt = cnt;
          obs.push_back(cur);
          cnt = 0;
        end
        mem_done = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] e;
    int t;
    tbl[0] = '{16'd10, 16'd20, 16'd30, 16'd40, 32'h281E140A, 32'h281E140A};
    tbl[1] = '{16'hFFFB, 16'd300, 16'd255, 16'd0, 32'h00FFFF00, 32'h00FFFF05};
    tbl[2] = '{16'h8000, 16'h7FFF, 16'd128, 16'd1, 32'h0180FF00, 32'h0180FFFF};
    tbl[3] = '{16'd256, 16'hFFFF, 16'd127, 16'd254, 32'hFE7F00FF, 32'hFE7F01FF};

    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        80'({pix_ready, mem_we, busy, frame_done, mem_addr, mem_wdata,
             h_pos, v_pos}), 80'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_outputs", 80'({busy, pix_ready, mem_we}), 80'(0));

    do_start();
    for (int i = 0; i < 4; i++) begin
      push(tbl[i].p0);
      push(tbl[i].p1);
      push(tbl[i].p2);
      push(tbl[i].p3);
      wait_writes(i + 1);
`ifdef PACKER_ABS_EN
      e = tbl[i].exp_abs;
`else
      e = tbl[i].exp;
`endif
      if (obs.size() > i) begin
        chk($sformatf("tbl_data%0d", i), 80'(obs[i].data), 80'(e));
        chk($sformatf("tbl_addr%0d", i), 80'(obs[i].addr), 80'(i));
        chk($sformatf("tbl_we_len%0d", i), 80'(obs[i].cnt), 80'(1));
      end
      chk($sformatf("tbl_hpos%0d", i), 80'(h_pos), 80'(4 * (i + 1)));
    end

    fix_dly = 10;
    for (int i = 0; i < 8; i++) push(rnd_pix());
    wait_writes(6);
    compare_words(4, 6);
    fix_dly = 0;

    for (int i = 0; i < 8; i++) push(rnd_pix());
    wait_writes(8);
    chk("eol_pos", 80'({h_pos, v_pos}), 80'({9'd0, 9'd1}));
    chk("eol_no_done", 80'(fd_cnt), 80'(0));
    for (int i = 0; i < 4; i++) push(rnd_pix());
    wait_writes(9);
    if (obs.size() > 8) chk("eol_addr", 80'(obs[8].addr), 80'(16'h0080));

    stray_en = 1'b1;
    gap_en = 1'b1;
    rand_dly = 1'b1;
    for (int n = 36; n < W * (TB_V_LAST + 1); n++) begin
      if (n / W == TB_V_LAST) push(16'(n % W));
      else push(rnd_pix());
    end
    wait_writes(NWORDS);
    repeat (5) @(negedge clk);
    compare_words(0, NWORDS);
    chk("frame_words", 80'(obs.size()), 80'(NWORDS));
    if (obs.size() >= NWORDS) begin
      chk("last_addr", 80'(obs[NWORDS-1].addr),
          80'({9'(TB_V_LAST), 7'(TB_H_LAST / 4)}));
      chk("last_data", 80'(obs[NWORDS-1].data), 80'(32'h1F1E1D1C));
    end
    chk("frame_done_once", 80'(fd_cnt), 80'(1));
    chk("end_state", 80'({busy, h_pos, v_pos}),
        80'({1'b0, 9'(TB_H_LAST), 9'(TB_V_LAST)}));

    stray_en = 1'b0;
    gap_en = 1'b0;
    rand_dly = 1'b0;
    do_start();
    for (int i = 0; i < 6; i++) push(rnd_pix());
    wait_writes(1);
    t = 0;
    while (q.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("start_ignored", 80'({busy, h_pos, v_pos}),
        80'({1'b1, 9'd6, 9'd0}));

    fix_dly = 50;
    push(rnd_pix());
    push(rnd_pix());
    t = 0;
    while (!mem_we && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("we_before_abort", 80'(mem_we), 80'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_async", 80'({mem_we, busy, pix_ready, h_pos}), 80'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    q.delete();
    fix_dly = 0;
    do_start();
    for (int i = 0; i < 4; i++) push(rnd_pix());
    wait_writes(1);
    if (obs.size() > 0) begin
      chk("restart_addr", 80'(obs[0].addr), 80'(0));
      chk("restart_data", 80'(obs[0].data), 80'(ref_data(0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
